gpio_irq_ctrl: RTL and testbench
================================

// Module: gpio_irq_ctrl
// PURPOSE
//  APB slave that consumes the GPIO input pins (same i_port pins the GPIO port block reads) and
//  raises one interrupt from enabled per-pin level/edge events. Sits beside the GPIO port slave
//  on the APB bus, downstream of the pads. Software enables, configures, observes and clears
//  events through five word-indexed registers.
// PARAMETERS
//  N_PINS       32  number of GPIO inputs monitored (1..32, data bits above N_PINS read 0)
//  ADDR_W        3  width of PADDR (word index)
//  SYNC_STAGES   2  flip-flop synchronizer depth per pin (>=2)
// PORTS
//  PCLK      in   1       bus/system clock, all logic rising-edge
//  PRESETn   in   1       asynchronous active-low reset
//  PSEL      in   1       APB select
//  PENABLE   in   1       APB access phase
//  PWRITE    in   1       1 write, 0 read
//  PADDR     in   ADDR_W  register word index
//  PWDATA    in   32      write data
//  PSTRB     in   4       byte write strobes
//  PRDATA    out  32      read data
//  PREADY    out  1       always 1 (zero wait states)
//  PSLVERR   out  1       error response, valid in access phase
//  gpio_in   in   N_PINS  asynchronous pad inputs
//  irq       out  1       registered interrupt, active high
// BEHAVIOUR
//  Reset: all registers, sync flops, prev-sample, PRDATA, PSLVERR, irq = 0; PREADY = 1.
//  Registers (idx): 0 IRQ_EN rw; 1 IRQ_TYPE rw (0 level, 1 edge); 2 IRQ_POL rw (1 high/rising,
//   0 low/falling); 3 IRQ_PEND rw1c; 4 RAW ro (synchronized inputs).
//  Write commits on PSEL&PENABLE&PWRITE rising edge, byte lane k only when PSTRB[k]=1.
//  PSLVERR=1 in access phase for idx>4 or write to RAW; no state change on error; PRDATA=0.
//  Read: PRDATA driven combinationally from idx during PSEL&!PWRITE; 0 otherwise.
//  Sync: gpio_in -> SYNC_STAGES flops -> s; prev <= s each cycle.
//  Event per pin i: level: s[i]==POL[i]; edge: rising (s&~prev) if POL=1, falling (~s&prev) if 0.
//  Settle counter: after reset deassert, edge events suppressed for SYNC_STAGES+1 cycles
//   (counter saturates, then held); level events never suppressed.
//  PEND[i] (edge): set on event & EN[i]; cleared by W1C; set wins over simultaneous clear.
//  PEND[i] (level): reads live event & EN[i]; W1C has no effect.
//  Changing TYPE/POL/EN never creates an edge event; clearing EN does not clear latched PEND.
//  irq <= |(PEND & EN) registered; latency pad edge -> PEND = SYNC_STAGES+1 clk, -> irq +1 clk.
//  Pulses shorter than one PCLK may be missed; no pulse stretching.
//  PRESETn low mid-transfer aborts it; all state returns to reset values asynchronously.
// STRUCTURE
//  Package gpio_irq_pkg: register index localparams (IDX_EN..IDX_RAW), TYPE_LEVEL/TYPE_EDGE,
//   POL_LOW/POL_HIGH encodings, byte-strobe merge function.
//  Sub-module gpio_sync_edge (per-pin vector: synchronizer, prev flop, rise/fall outputs),
//   instantiated once with width N_PINS; top holds APB decode, registers, settle counter, irq.
// TESTING
//  1 Reset, read idx 0..4 -> all 0, PSLVERR=0, irq=0.
//  2 EN=0x1, TYPE=0x1, POL=0x1; gpio_in[0] 0->1 -> PEND=0x1 after 3 clk, irq=1 after 4; write
//    PEND=0x1 -> PEND=0, irq=0 next cycle.
//  3 Level-low pin 5: EN=0x20, TYPE=0, POL=0, gpio_in[5]=0 -> PEND=0x20, irq=1; W1C 0x20 ->
//    PEND stays 0x20; gpio_in[5]=1 -> PEND=0 after 2 clk.
//  4 W1C on pin 0 in same cycle as new rising edge -> PEND[0] stays 1.
//  5 PSTRB=4'b0001 write EN=0xFFFFFFFF -> EN=0x000000FF; write idx 4 or read idx 6 -> PSLVERR=1,
//    registers unchanged.
//  6 gpio_in=0xFFFF_FFFF held through reset release, edge-rising all enabled -> no PEND set;
//    assert PRESETn=0 with PEND=0x3 -> PEND=0, irq=0 immediately.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: register map, type/polarity encodings and byte-lane write merge
package gpio_irq_pkg;
  localparam int unsigned IDX_EN   = 0;
  localparam int unsigned IDX_TYPE = 1;
  localparam int unsigned IDX_POL  = 2;
  localparam int unsigned IDX_PEND = 3;
  localparam int unsigned IDX_RAW  = 4;
  localparam logic TYPE_LEVEL = 1'b0;
  localparam logic TYPE_EDGE  = 1'b1;
  localparam logic POL_LOW    = 1'b0;
  localparam logic POL_HIGH   = 1'b1;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = strb[k] ? wdata[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction
endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// gpio_irq_ctrl_if: APB bus bundle between the bus master and the GPIO interrupt slave
interface gpio_irq_ctrl_if #(parameter int ADDR_W = 3);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master(output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                 input PRDATA, PREADY, PSLVERR);
  modport slave(input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: per-pin synchronizer chain with previous-sample flop and rise/fall detect
module gpio_sync_edge #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
    s      = sync_q[STAGES-1];
    rise   = s & ~prev_q;
    fall   = ~s & prev_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: APB slave turning enabled per-pin level/edge GPIO events into one interrupt
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int N_PINS      = 32,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  gpio_irq_ctrl_if.slave    bus,
  input  logic [N_PINS-1:0] gpio_in,
  output logic              irq
);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int CNT_W  = $clog2(SETTLE + 1);
  logic [N_PINS-1:0] s, rise, fall, evt, live, view, edge_m, clr;
  logic [N_PINS-1:0] en_q, en_d, type_q, type_d, pol_q, pol_d, pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d, acc, err, wr, settled;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       idx, rdata;
  gpio_sync_edge #(.W(N_PINS), .STAGES(SYNC_STAGES)) u_sync (
    .clk(PCLK), .rst_n(PRESETn), .d(gpio_in), .s(s), .rise(rise), .fall(fall)
  );
  always_comb begin
    evt    = '0;
    live   = '0;
    view   = '0;
    edge_m = '0;
    for (int i = 0; i < N_PINS; i++) begin
      evt[i]    = (pol_q[i] == POL_LOW) ? fall[i] : rise[i];
      live[i]   = (s[i] ? (pol_q[i] == POL_HIGH) : (pol_q[i] == POL_LOW)) & en_q[i];
      edge_m[i] = type_q[i] == TYPE_EDGE;
      view[i]   = (type_q[i] == TYPE_LEVEL) ? live[i] : pend_q[i];
    end
    paddr   = bus.PADDR;
    idx     = 32'(paddr);
    acc     = bus.PSEL & bus.PENABLE;
    err     = (idx > IDX_RAW) || (bus.PWRITE && idx == IDX_RAW);
    wr      = acc & bus.PWRITE & ~err;
    clr     = (wr && idx == IDX_PEND) ? N_PINS'(strb_merge('0, bus.PWDATA, bus.PSTRB)) : '0;
    en_d    = (wr && idx == IDX_EN) ? N_PINS'(strb_merge(32'(en_q), bus.PWDATA, bus.PSTRB)) : en_q;
    type_d  = (wr && idx == IDX_TYPE) ? N_PINS'(strb_merge(32'(type_q), bus.PWDATA, bus.PSTRB)) : type_q;
    pol_d   = (wr && idx == IDX_POL) ? N_PINS'(strb_merge(32'(pol_q), bus.PWDATA, bus.PSTRB)) : pol_q;
    // edges are ignored until the synchronizer and prev flop hold real pad history
    settled = cnt_q == CNT_W'(SETTLE);
    cnt_d   = settled ? cnt_q : cnt_q + 1'b1;
    pend_d  = (pend_q & ~clr) | (settled ? evt & en_q & edge_m : '0);
    irq_d   = |(view & en_q);
    rdata   = (idx == IDX_EN)   ? 32'(en_q)   :
              (idx == IDX_TYPE) ? 32'(type_q) :
              (idx == IDX_POL)  ? 32'(pol_q)  :
              (idx == IDX_PEND) ? 32'(view)   :
              (idx == IDX_RAW)  ? 32'(s)      : '0;
  end
  assign bus.PRDATA  = (bus.PSEL && !bus.PWRITE) ? rdata : '0;
  assign bus.PSLVERR = acc & err;
  assign bus.PREADY  = 1'b1;
  assign irq         = irq_q;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      en_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      type_q <= type_d;
      pol_q  <= pol_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
    end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl: directed and random stimulus against a history-based reference model
module tb_gpio_irq_ctrl;
  localparam int S = 2;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] gpio_in = '0;
  logic        irq;
  int          total = 0;
  int          passed = 0;
  gpio_irq_ctrl_if #(.ADDR_W(3)) bus ();
  gpio_irq_ctrl #(.N_PINS(32), .ADDR_W(3), .SYNC_STAGES(S)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus), .gpio_in(gpio_in), .irq(irq)
  );
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // reference model: s is the pad value sampled S edges ago, prev the one before it
  logic [31:0] m_en, m_type, m_pol, m_pend;
  logic        m_irq;
  logic [31:0] hist[$];
  int          edges;

  function automatic logic [31:0] m_s();
    return (hist.size() >= S) ? hist[S-1] : 32'h0;
  endfunction
  function automatic logic [31:0] m_prev();
    return (hist.size() > S) ? hist[S] : 32'h0;
  endfunction
  function automatic logic [31:0] m_view();
    logic [31:0] live = ~(m_s() ^ m_pol) & m_en;
    return (m_type & m_pend) | (~m_type & live);
  endfunction
  function automatic logic [31:0] lanes(input logic [3:0] strb);
    logic [31:0] m = '0;
    for (int k = 0; k < 4; k++) if (strb[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction
  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0: return m_en;
      1: return m_type;
      2: return m_pol;
      3: return m_view();
      4: return m_s();
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] s, p, evt, mask, wd, clr;
    int idx;
    logic wr;
    if (!PRESETn) begin
      m_en = '0; m_type = '0; m_pol = '0; m_pend = '0; m_irq = 1'b0;
      hist.delete();
      edges = 0;
      return;
    end
    s    = m_s();
    p    = m_prev();
    evt  = (m_pol & s & ~p) | (~m_pol & ~s & p);
    idx  = int'(bus.PADDR);
    mask = lanes(bus.PSTRB);
    wd   = bus.PWDATA & mask;
    wr   = bus.PSEL && bus.PENABLE && bus.PWRITE && idx < 4;
    clr  = (wr && idx == 3) ? wd : 32'h0;
    m_irq  = |(m_view() & m_en);
    m_pend = (m_pend & ~clr) | ((edges >= S + 1) ? (evt & m_en & m_type) : 32'h0);
    if (wr && idx == 0) m_en   = (m_en & ~mask) | wd;
    if (wr && idx == 1) m_type = (m_type & ~mask) | wd;
    if (wr && idx == 2) m_pol  = (m_pol & ~mask) | wd;
    hist.push_front(gpio_in);
    if (hist.size() > S + 1) void'(hist.pop_back());
    edges++;
  endtask

  initial forever begin
    @(posedge PCLK or negedge PRESETn);
    model_step();
  end

  initial forever begin
    int idx;
    @(negedge PCLK);
    #2;
    if (PRESETn) begin
      idx = int'(bus.PADDR);
      chk("irq", irq, m_irq);
      chk("prdata", bus.PRDATA, (bus.PSEL && !bus.PWRITE) ? m_read(idx) : 32'h0);
      chk("pslverr", bus.PSLVERR, bus.PSEL && bus.PENABLE && (idx > 4 || (bus.PWRITE && idx == 4)));
      chk("pready", bus.PREADY, 1);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge PCLK);
  endtask
  task automatic idle();
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
  endtask
  task automatic hold(input int idx);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 3'(idx);
  endtask
  task automatic apb_wr(input int idx, input logic [31:0] d, input logic [3:0] strb, output logic err);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 3'(idx); bus.PWDATA = d; bus.PSTRB = strb;
    step();
    bus.PENABLE = 1;
    #1 err = bus.PSLVERR;
    step();
    idle();
  endtask
  task automatic wr(input int idx, input logic [31:0] d);
    logic e;
    apb_wr(idx, d, 4'hF, e);
  endtask
  task automatic apb_rd(input int idx, output logic [31:0] d, output logic err);
    hold(idx);
    step();
    bus.PENABLE = 1;
    #1 begin d = bus.PRDATA; err = bus.PSLVERR; end
    step();
    idle();
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    int r;
    idle();
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
    step(2);
    PRESETn = 1;
    #1 chk("rst_irq", irq, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      apb_rd(i, d, e);
      chk($sformatf("rst_reg%0d", i), d, 0);
      chk($sformatf("rst_err%0d", i), e, 0);
    end
    // rising edge on pin 0: PEND after 3 clocks, irq one later, W1C clears
    wr(0, 1); wr(1, 1); wr(2, 1);
    hold(3);
    gpio_in = 32'h1;
    step(2);
    #1 chk("t2_pend_2clk", bus.PRDATA, 0);
    step();
    #1 begin chk("t2_pend_3clk", bus.PRDATA, 1); chk("t2_irq_3clk", irq, 0); end
    step();
    #1 chk("t2_irq_4clk", irq, 1);
    step();
    wr(3, 1);
    hold(3);
    #1 begin chk("t2_pend_clr", bus.PRDATA, 0); chk("t2_irq_lag", irq, 1); end
    step();
    #1 chk("t2_irq_clr", irq, 0);
    step();
    // level-low pin 5 ignores W1C and follows the pad
    wr(0, 32'h20); wr(1, 0); wr(2, 0);
    hold(3);
    #1 begin chk("t3_pend", bus.PRDATA, 32'h20); chk("t3_irq", irq, 1); end
    step();
    wr(3, 32'h20);
    hold(3);
    #1 chk("t3_w1c_ignored", bus.PRDATA, 32'h20);
    step();
    gpio_in = gpio_in | 32'h20;
    step();
    #1 chk("t3_pend_1clk", bus.PRDATA, 32'h20);
    step();
    #1 chk("t3_pend_2clk", bus.PRDATA, 0);
    step();
    // W1C committing on the same edge that latches a new rising edge
    wr(0, 1); wr(1, 1); wr(2, 1);
    gpio_in[0] = 1'b0;
    step(4);
    gpio_in[0] = 1'b1;
    step();
    apb_wr(3, 1, 4'hF, e);
    hold(3);
    #1 chk("t4_set_wins", bus.PRDATA, 1);
    step();
    idle();
    // byte strobes and error responses
    apb_wr(0, 32'hFFFF_FFFF, 4'b0001, e);
    apb_rd(0, d, e);
    chk("t5_strb", d, 32'hFF);
    apb_wr(4, 32'hDEAD_BEEF, 4'hF, e);
    chk("t5_raw_wr_err", e, 1);
    apb_rd(6, d, e);
    chk("t5_rd6_err", e, 1);
    chk("t5_rd6_data", d, 0);
    apb_wr(7, 32'h0, 4'hF, e);
    chk("t5_wr7_err", e, 1);
    apb_rd(0, d, e);
    chk("t5_en_kept", d, 32'hFF);
    apb_rd(4, d, e);
    chk("t5_raw", d, 32'h21);
    chk("t5_raw_err", e, 0);
    // inputs high through reset release, then async reset with PEND set
    gpio_in = 32'hFFFF_FFFF;
    #3 PRESETn = 0;
    step(2);
    PRESETn = 1;
    wr(0, 32'hFFFF_FFFF); wr(1, 32'hFFFF_FFFF); wr(2, 32'hFFFF_FFFF);
    step(3);
    hold(3);
    #1 begin chk("t6_no_pend", bus.PRDATA, 0); chk("t6_no_irq", irq, 0); end
    step();
    gpio_in = 32'h0;
    step(4);
    gpio_in = 32'h3;
    step(4);
    #1 begin chk("t6_pend3", bus.PRDATA, 32'h3); chk("t6_irq3", irq, 1); end
    #2 PRESETn = 0;
    #1 begin chk("t6_rst_pend", bus.PRDATA, 0); chk("t6_rst_irq", irq, 0); end
    step();
    PRESETn = 1;
    idle();
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      gpio_in = ($urandom_range(0, 19) == 0) ? $urandom : gpio_in ^ ($urandom & $urandom & $urandom);
      r = $urandom_range(0, 99);
      if (r < 30) apb_wr((r < 20) ? $urandom_range(0, 3) : $urandom_range(0, 7), $urandom, 4'($urandom), e);
      else if (r < 55) apb_rd($urandom_range(0, 7), d, e);
      else if (r < 56) begin
        #3 PRESETn = 0;
        step();
        PRESETn = 1;
      end else begin
        if ($urandom_range(0, 1) == 1) hold($urandom_range(0, 7));
        step($urandom_range(1, 3));
        idle();
      end
    end
    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
